// File: rtl/overlay_sequencer_if.sv
// Handshake bundle between the overlay sequencer and the game/VGA logic.
// The master drives the event pulses; the slave (sequencer) drives the overlay state.
interface overlay_sequencer_if;
  logic       start_of_frame;
  logic       goal_p1;
  logic       goal_p2;
  logic       restart;
  logic       goal_show;
  logic       game_over_show;
  logic       freeze;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] winner;

  modport master (
    output start_of_frame, goal_p1, goal_p2, restart,
    input  goal_show, game_over_show, freeze, score_p1, score_p2, winner
  );

  modport slave (
    input  start_of_frame, goal_p1, goal_p2, restart,
    output goal_show, game_over_show, freeze, score_p1, score_p2, winner
  );
endinterface

// File: rtl/overlay_sequencer.sv
// Score keeping and goal / game-over overlay sequencing for the pong game.
// Define OVERLAY_BLINK_EN to make the game-over icon blink every BLINK_FRAMES frames.
module overlay_sequencer #(
  parameter int unsigned GOAL_FRAMES  = 120,
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  overlay_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCORE_W = 4;

  localparam logic [CNT_W-1:0]   GOAL_LAST = CNT_W'(GOAL_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Reject illegal parameterisations at elaboration time.
  if (GOAL_FRAMES < 1 || GOAL_FRAMES > 255) begin : g_bad_goal
    $error("GOAL_FRAMES out of range 1..255");
  end
  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
    $error("WIN_SCORE out of range 1..15");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
    $error("BLINK_FRAMES out of range 1..255");
  end

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    GOAL_SHOW = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [SCORE_W-1:0]   score_p1_q, score_p1_d;
  logic [SCORE_W-1:0]   score_p2_q, score_p2_d;
  logic [1:0]           winner_q, winner_d;
  logic                 goal_show_q, goal_show_d;
  logic                 over_show_q, over_show_d;
  logic                 freeze_q, freeze_d;
`ifdef OVERLAY_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
`endif

  logic win_p1, win_p2;

  // Scores are final while the goal icon is up, so the win test uses the registered values.
  assign win_p1 = (score_p1_q >= WIN);
  assign win_p2 = (score_p2_q >= WIN);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    winner_d    = winner_q;
    goal_show_d = goal_show_q;
    over_show_d = over_show_q;
    freeze_d    = freeze_q;
`ifdef OVERLAY_BLINK_EN
    blink_cnt_d = blink_cnt_q;
`endif

    if (bus.restart) begin
      state_d     = PLAY;
      frame_cnt_d = '0;
      score_p1_d  = '0;
      score_p2_d  = '0;
      winner_d    = 2'b00;
      goal_show_d = 1'b0;
      over_show_d = 1'b0;
      freeze_d    = 1'b0;
`ifdef OVERLAY_BLINK_EN
      blink_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        PLAY: begin
          if (bus.goal_p1 || bus.goal_p2) begin
            state_d     = GOAL_SHOW;
            frame_cnt_d = '0;
            goal_show_d = 1'b1;
            freeze_d    = 1'b1;
            if (bus.goal_p1 && score_p1_q != SCORE_MAX) begin
              score_p1_d = score_p1_q + SCORE_W'(1);
            end
            if (bus.goal_p2 && score_p2_q != SCORE_MAX) begin
              score_p2_d = score_p2_q + SCORE_W'(1);
            end
          end
        end

        GOAL_SHOW: begin
          if (bus.start_of_frame) begin
            if (frame_cnt_q == GOAL_LAST) begin
              frame_cnt_d = '0;
              goal_show_d = 1'b0;
              if (win_p1 || win_p2) begin
                state_d     = GAME_OVER;
                winner_d    = {win_p2, win_p1};
                over_show_d = 1'b1;
                freeze_d    = 1'b1;
`ifdef OVERLAY_BLINK_EN
                blink_cnt_d = '0;
`endif
              end else begin
                state_d  = PLAY;
                freeze_d = 1'b0;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
          end
        end

        GAME_OVER: begin
`ifdef OVERLAY_BLINK_EN
          // Icon toggles each time BLINK_FRAMES frames have elapsed.
          if (bus.start_of_frame) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              over_show_d = ~over_show_q;
            end else begin
              blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
          end
`else
          over_show_d = 1'b1;
`endif
        end

        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  // State and output registers; RESET wins over every other input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= PLAY;
      frame_cnt_q <= '0;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      winner_q    <= 2'b00;
      goal_show_q <= 1'b0;
      over_show_q <= 1'b0;
      freeze_q    <= 1'b0;
`ifdef OVERLAY_BLINK_EN
      blink_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      winner_q    <= winner_d;
      goal_show_q <= goal_show_d;
      over_show_q <= over_show_d;
      freeze_q    <= freeze_d;
`ifdef OVERLAY_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  assign bus.goal_show      = goal_show_q;
  assign bus.game_over_show = over_show_q;
  assign bus.freeze         = freeze_q;
  assign bus.score_p1       = score_p1_q;
  assign bus.score_p2       = score_p2_q;
  assign bus.winner         = winner_q;

endmodule

// File: tb/tb_overlay_sequencer.sv
// Self-checking bench for overlay_sequencer: event-level reference model plus
// hand-computed expectations for the small-parameter scenarios.
module tb_overlay_sequencer;

  localparam int unsigned GOAL_FRAMES  = 3;
  localparam int unsigned WIN_SCORE    = 2;
  localparam int unsigned BLINK_FRAMES = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  overlay_sequencer_if bus ();

  overlay_sequencer #(
    .GOAL_FRAMES  (GOAL_FRAMES),
    .WIN_SCORE    (WIN_SCORE),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int  n_total  = 0;
  int  n_passed = 0;
  bit  chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: scores, frames of goal icon still owed, game-over flag,
  // and frames elapsed since the game ended.
  int m_s1 = 0, m_s2 = 0, m_left = 0, m_sofs = 0, m_win = 0;
  bit m_over = 1'b0;

  always @(posedge clk) begin
    int s1, s2, left, sofs, win;
    bit over;
    s1 = m_s1; s2 = m_s2; left = m_left; sofs = m_sofs; win = m_win; over = m_over;
    if (reset || bus.restart) begin
      s1 = 0; s2 = 0; left = 0; sofs = 0; win = 0; over = 1'b0;
    end else if (left > 0) begin
      if (bus.start_of_frame) begin
        left = left - 1;
        if (left == 0 && (s1 >= WIN_SCORE || s2 >= WIN_SCORE)) begin
          over = 1'b1;
          sofs = 0;
          win  = (s1 >= WIN_SCORE ? 1 : 0) + (s2 >= WIN_SCORE ? 2 : 0);
        end
      end
    end else if (over) begin
      if (bus.start_of_frame) sofs = sofs + 1;
    end else if (bus.goal_p1 || bus.goal_p2) begin
      if (bus.goal_p1 && s1 < 15) s1 = s1 + 1;
      if (bus.goal_p2 && s2 < 15) s2 = s2 + 1;
      left = GOAL_FRAMES;
    end
    m_s1 <= s1; m_s2 <= s2; m_left <= left; m_sofs <= sofs; m_win <= win; m_over <= over;
  end

  function automatic int exp_over_show();
    if (!m_over) return 0;
`ifdef OVERLAY_BLINK_EN
    return ((m_sofs / BLINK_FRAMES) % 2 == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("score_p1",       int'(bus.score_p1),       m_s1);
      chk("score_p2",       int'(bus.score_p2),       m_s2);
      chk("winner",         int'(bus.winner),         m_win);
      chk("goal_show",      int'(bus.goal_show),      (m_left > 0) ? 1 : 0);
      chk("game_over_show", int'(bus.game_over_show), exp_over_show());
      chk("freeze",         int'(bus.freeze),         (m_left > 0 || m_over) ? 1 : 0);
    end
  end

  task automatic cyc(input logic sof, input logic g1, input logic g2, input logic rs, input logic rst);
    @(posedge clk);
    #1;
    bus.start_of_frame = sof;
    bus.goal_p1        = g1;
    bus.goal_p2        = g2;
    bus.restart        = rs;
    reset              = rst;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic goal(input logic g1, input logic g2);
    cyc(1'b0, g1, g2, 1'b0, 1'b0);
    idle();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
    end
  endtask

  task automatic pin_cleared(input string tag);
    chk({tag, ".score_p1"},  int'(bus.score_p1), 0);
    chk({tag, ".score_p2"},  int'(bus.score_p2), 0);
    chk({tag, ".winner"},    int'(bus.winner), 0);
    chk({tag, ".goal_show"}, int'(bus.goal_show), 0);
    chk({tag, ".over_show"}, int'(bus.game_over_show), 0);
    chk({tag, ".freeze"},    int'(bus.freeze), 0);
  endtask

  int blink_pat [5];

  initial begin
    bus.start_of_frame = 1'b0;
    bus.goal_p1        = 1'b0;
    bus.goal_p2        = 1'b0;
    bus.restart        = 1'b0;
`ifdef OVERLAY_BLINK_EN
    blink_pat = '{1, 1, 0, 0, 1};
`else
    blink_pat = '{1, 1, 1, 1, 1};
`endif

    // Reset state.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk_en = 1'b1;
    pin_cleared("reset");

    // Single goal: one-cycle latency, goal pulse ignored while showing, 3 frames of icon.
    goal(1'b1, 1'b0);
    chk("goal1.score_p1",  int'(bus.score_p1), 1);
    chk("goal1.goal_show", int'(bus.goal_show), 1);
    chk("goal1.freeze",    int'(bus.freeze), 1);
    goal(1'b1, 1'b0);
    chk("ignored.score_p1", int'(bus.score_p1), 1);
    frames(2);
    chk("frame2.goal_show", int'(bus.goal_show), 1);
    frames(1);
    chk("frame3.goal_show", int'(bus.goal_show), 0);
    chk("frame3.freeze",    int'(bus.freeze), 0);

    // Restart overrides a simultaneous goal.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    pin_cleared("restart");

    // Player 2 wins after two goals.
    goal(1'b0, 1'b1);
    frames(3);
    goal(1'b0, 1'b1);
    frames(3);
    chk("p2win.winner",    int'(bus.winner), 2);
    chk("p2win.over_show", int'(bus.game_over_show), 1);
    chk("p2win.score_p2",  int'(bus.score_p2), 2);
    chk("p2win.freeze",    int'(bus.freeze), 1);
    goal(1'b1, 1'b0);
    chk("over_ignored.score_p1", int'(bus.score_p1), 0);
    for (int i = 1; i < 5; i++) begin
      frames(1);
      chk($sformatf("blink%0d", i), int'(bus.game_over_show), blink_pat[i]);
    end

    // RESET mid game-over beats restart and goals.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    pin_cleared("reset_over");

    // Draw: 1-1 then a double goal.
    goal(1'b1, 1'b0);
    frames(3);
    goal(1'b0, 1'b1);
    frames(3);
    goal(1'b1, 1'b1);
    chk("draw.score_p1",  int'(bus.score_p1), 2);
    chk("draw.score_p2",  int'(bus.score_p2), 2);
    chk("draw.goal_show", int'(bus.goal_show), 1);
    frames(3);
    chk("draw.winner",    int'(bus.winner), 3);
    chk("draw.over_show", int'(bus.game_over_show), 1);

    // Restart from game-over.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    pin_cleared("restart_over");

    // RESET mid goal icon; frames in PLAY have no effect.
    goal(1'b1, 1'b0);
    frames(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    pin_cleared("reset_goal");
    frames(2);
    chk("play_sof.goal_show", int'(bus.goal_show), 0);

    idle();
    idle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
